// File: rtl/pipe_adder_pkg.sv
// Shared definitions for pipe_adder: slice-width derivation, parameter
// legality check, and per-stage record field widths.
package pipe_adder_pkg;

  // Bits added per pipeline stage.
  function automatic int unsigned slice_width(input int unsigned width,
                                              input int unsigned stages);
    return (stages == 0) ? 1 : width / stages;
  endfunction

  // Legal only when WIDTH splits evenly into STAGES non-empty slices.
  function automatic bit params_ok(input int unsigned width,
                                   input int unsigned stages);
    return (width >= 1) && (stages >= 1) && (stages <= width) &&
           ((width % stages) == 0);
  endfunction

  // Sum bits already valid after stage idx.
  function automatic int unsigned sum_width(input int unsigned slice,
                                            input int unsigned idx);
    return (idx + 1) * slice;
  endfunction

  // Operand bits still to be consumed after stage idx.
  function automatic int unsigned rem_width(input int unsigned width,
                                            input int unsigned slice,
                                            input int unsigned idx);
    return width - sum_width(slice, idx);
  endfunction

endpackage

// File: rtl/pipe_adder_slice.sv
// One registered stage of pipe_adder: adds slice IDX of the operands with the
// incoming carry, keeps the partial sum and forwards the operands.
//   clk, rst          : clock, async active-high reset
//   en                : stage advances this cycle
//   up_valid/up_carry : upstream beat flag and carry
//   up_sum/up_a/up_b  : upstream partial sum and operands
//   valid/carry       : registered beat flag and slice carry out
//   sum/a_pass/b_pass : registered partial sum and forwarded operands
module adder_slice
  import pipe_adder_pkg::*;
#(
  parameter int unsigned SLICE = 4,
  parameter int unsigned WIDTH = 8,
  parameter int unsigned IDX   = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             up_valid,
  input  logic             up_carry,
  input  logic [WIDTH-1:0] up_sum,
  input  logic [WIDTH-1:0] up_a,
  input  logic [WIDTH-1:0] up_b,
  output logic             valid,
  output logic             carry,
  output logic [WIDTH-1:0] sum,
  output logic [WIDTH-1:0] a_pass,
  output logic [WIDTH-1:0] b_pass
);

  localparam int unsigned LO = IDX * SLICE;

  logic [SLICE:0]   add_c;
  logic [WIDTH-1:0] sum_next;

  // Slice add; lower slices are copied, upper slices are still zero.
  always_comb begin
    add_c    = {1'b0, up_a[LO +: SLICE]} + {1'b0, up_b[LO +: SLICE]} +
               (SLICE+1)'(up_carry);
    sum_next = up_sum;
    sum_next[LO +: SLICE] = add_c[SLICE-1:0];
  end

  // Stage register; data only captured for a real beat.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid  <= 1'b0;
      carry  <= 1'b0;
      sum    <= '0;
      a_pass <= '0;
      b_pass <= '0;
    end else if (en) begin
      valid <= up_valid;
      if (up_valid) begin
        carry  <= add_c[SLICE];
        sum    <= sum_next;
        a_pass <= up_a;
        b_pass <= up_b;
      end
    end
  end

endmodule

// File: rtl/pipe_adder.sv
// Pipelined ripple-carry adder with valid/ready on both sides. The WIDTH-bit
// add is split into STAGES equal slices, one per registered stage.
//   clk, rst            : clock, async active-high reset
//   in_valid/in_ready   : operand handshake (in_ready is combinational)
//   a, b, ci            : operands and carry in
//   out_valid/out_ready : result handshake
//   s, co, ov           : sum, unsigned carry out, signed overflow
module pipe_adder
  import pipe_adder_pkg::*;
#(
  parameter int unsigned WIDTH  = 8,
  parameter int unsigned STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             ci,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] s,
  output logic             co,
  output logic             ov
);

  localparam int unsigned SLICE = slice_width(WIDTH, STAGES);
  localparam int unsigned LAST  = STAGES - 1;

  if (!params_ok(WIDTH, STAGES)) begin : g_bad_params
    $error("pipe_adder: WIDTH must be a non-zero multiple of STAGES");
  end

  logic [STAGES-1:0] v;
  logic [STAGES-1:0] c;
  logic [STAGES-1:0] adv;
  logic [WIDTH-1:0]  sum_q [STAGES];
  logic [WIDTH-1:0]  a_q   [STAGES];
  logic [WIDTH-1:0]  b_q   [STAGES];
  logic              chain;

  // Ready chain: a stage may move when it is empty or its successor moves.
  always_comb begin
    adv   = '0;
    chain = out_ready;
    for (int k = int'(STAGES) - 1; k >= 0; k--) begin
      chain  = !v[k] | chain;
      adv[k] = chain;
    end
  end

  assign in_ready = !rst & adv[0];

  for (genvar k = 0; k < int'(STAGES); k++) begin : g_stage
    logic             up_valid;
    logic             up_carry;
    logic [WIDTH-1:0] up_sum;
    logic [WIDTH-1:0] up_a;
    logic [WIDTH-1:0] up_b;

    if (k == 0) begin : g_first
      assign up_valid = in_valid;
      assign up_carry = ci;
      assign up_sum   = '0;
      assign up_a     = a;
      assign up_b     = b;
    end else begin : g_next
      assign up_valid = v[k-1];
      assign up_carry = c[k-1];
      assign up_sum   = sum_q[k-1];
      assign up_a     = a_q[k-1];
      assign up_b     = b_q[k-1];
    end

    adder_slice #(
      .SLICE (SLICE),
      .WIDTH (WIDTH),
      .IDX   (k)
    ) u_slice (
      .clk      (clk),
      .rst      (rst),
      .en       (adv[k]),
      .up_valid (up_valid),
      .up_carry (up_carry),
      .up_sum   (up_sum),
      .up_a     (up_a),
      .up_b     (up_b),
      .valid    (v[k]),
      .carry    (c[k]),
      .sum      (sum_q[k]),
      .a_pass   (a_q[k]),
      .b_pass   (b_q[k])
    );
  end

  // Result taken straight from the last stage registers.
  assign out_valid = v[LAST];
  assign s         = sum_q[LAST];
  assign co        = c[LAST];
  assign ov        = (a_q[LAST][WIDTH-1] == b_q[LAST][WIDTH-1]) &
                     (sum_q[LAST][WIDTH-1] != a_q[LAST][WIDTH-1]);

endmodule

// File: tb/tb_pipe_adder.sv
module tb_pipe_adder;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid, in_ready, ci, out_valid, out_ready, co, ov;
  logic [7:0] a, b, s;
  logic       main_done;

  int errors = 0;
  int checks = 0;
  int unsigned mq[$];

  always #5 clk = ~clk;

  pipe_adder #(.WIDTH(8), .STAGES(2)) u_dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .ci(ci), .out_valid(out_valid), .out_ready(out_ready),
    .s(s), .co(co), .ov(ov)
  );

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference: {ov, co, s} from plain integer arithmetic on w-bit operands.
  function automatic int unsigned ref_add(input int w, input int unsigned x,
                                          input int unsigned y,
                                          input int unsigned cin);
    int unsigned full, sm, cy, ovf;
    int sx, sy, sv;
    full = x + y + cin;
    sm   = full % (32'd1 << w);
    cy   = full >> w;
    sx   = (x >= (32'd1 << (w - 1))) ? int'(x) - (1 << w) : int'(x);
    sy   = (y >= (32'd1 << (w - 1))) ? int'(y) - (1 << w) : int'(y);
    sv   = sx + sy + int'(cin);
    ovf  = ((sv > (1 << (w - 1)) - 1) || (sv < -(1 << (w - 1)))) ? 1 : 0;
    return (ovf << (w + 1)) | (cy << w) | sm;
  endfunction

  // One cycle on the 8-bit DUT with scoreboard tracking.
  task automatic main_cycle(input logic iv, input logic [7:0] ia,
                            input logic [7:0] ib, input logic ici,
                            input logic ordy, output logic took,
                            output logic popped);
    @(negedge clk);
    in_valid = iv; a = ia; b = ib; ci = ici; out_ready = ordy;
    #1;
    popped = out_valid & out_ready;
    took   = in_valid & in_ready;
    if (popped) begin
      if (mq.size() == 0) check("extra_out", 32'(out_valid), 32'd0);
      else check("stream", 32'({ov, co, s}), mq.pop_front());
    end
    if (took) mq.push_back(ref_add(8, 32'(ia), 32'(ib), 32'(ici)));
  endtask

  // Single beat, unstalled; measures cycles until out_valid.
  task automatic lat_beat(input string tag, input logic [7:0] ta,
                          input logic [7:0] tb_v, input logic tci);
    int n;
    @(negedge clk);
    in_valid = 1'b1; a = ta; b = tb_v; ci = tci; out_ready = 1'b1;
    #1;
    check({tag, "_rdy"}, 32'(in_ready), 32'd1);
    n = 0;
    do begin
      @(negedge clk);
      in_valid = 1'b0;
      #1;
      n++;
    end while (!out_valid && n < 10);
    check({tag, "_lat"}, 32'(n), 32'd2);
    check({tag, "_sum"}, 32'({ov, co, s}),
          ref_add(8, 32'(ta), 32'(tb_v), 32'(tci)));
  endtask

  // Width-4 corner configurations: STAGES=1 and STAGES=4.
  for (genvar g = 0; g < 2; g++) begin : g_corner
    localparam int ST = (g == 0) ? 1 : 4;
    logic       civ, cir, cci, cov_v, cor, cco, cov;
    logic [3:0] ca, cb, cs;
    logic       done;
    int         n, idx, got, guard;
    int unsigned q[$];

    pipe_adder #(.WIDTH(4), .STAGES(ST)) u_corner (
      .clk(clk), .rst(rst), .in_valid(civ), .in_ready(cir),
      .a(ca), .b(cb), .ci(cci), .out_valid(cov_v), .out_ready(cor),
      .s(cs), .co(cco), .ov(cov)
    );

    initial begin
      done = 1'b0; civ = 1'b0; cor = 1'b0; ca = '0; cb = '0; cci = 1'b0;
      wait (main_done === 1'b1);
      @(negedge clk);
      civ = 1'b1; ca = 4'h9; cb = 4'h8; cci = 1'b1; cor = 1'b1;
      n = 0;
      do begin
        @(negedge clk);
        civ = 1'b0;
        #1;
        n++;
      end while (!cov_v && n < 10);
      check($sformatf("c%0d_lat", ST), 32'(n), 32'(ST));
      check($sformatf("c%0d_lat_sum", ST), 32'({cov, cco, cs}),
            ref_add(4, 32'h9, 32'h8, 32'h1));
      idx = 0; got = 0; guard = 0;
      while (got < 512 && guard < 6000) begin
        @(negedge clk);
        cor = 1'($urandom_range(0, 1));
        civ = (idx < 512);
        ca  = idx[3:0]; cb = idx[7:4]; cci = idx[8];
        #1;
        if (cov_v && cor) begin
          if (q.size() == 0) check($sformatf("c%0d_extra", ST), 32'(cov_v), 32'd0);
          else check($sformatf("c%0d_sum", ST), 32'({cov, cco, cs}), q.pop_front());
          got++;
        end
        if (civ && cir) begin
          q.push_back(ref_add(4, 32'(ca), 32'(cb), 32'(cci)));
          idx++;
        end
        guard++;
      end
      civ = 1'b0;
      check($sformatf("c%0d_count", ST), 32'(got), 32'd512);
      done = 1'b1;
    end
  end

  initial begin
    logic took, popped;
    int   pops, guard;
    bit   sent;
    main_done = 1'b0;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0; ci = 1'b0;
    #1;
    check("rst_in_ready", 32'(in_ready), 32'd0);
    check("rst_out", 32'({out_valid, ov, co, s}), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // Directed sums including carry and overflow corners.
    lat_beat("d0f01", 8'h0F, 8'h01, 1'b0);
    lat_beat("dff01", 8'hFF, 8'h01, 1'b0);
    lat_beat("d7f01", 8'h7F, 8'h01, 1'b0);
    lat_beat("d8080", 8'h80, 8'h80, 1'b1);

    // Back-to-back stream: one result per cycle starting two cycles in.
    for (int cyc = 0; cyc < 9; cyc++) begin
      main_cycle(cyc < 6, 8'(cyc), 8'(2 * cyc), cyc[0], 1'b1, took, popped);
      if (cyc < 6) check("b2b_rdy", 32'(took), 32'd1);
      if (cyc >= 2 && cyc <= 7) check("b2b_out", 32'(popped), 32'd1);
    end
    check("b2b_left", 32'(mq.size()), 32'd0);

    // Backpressure: two beats fill the pipe, third waits.
    main_cycle(1'b1, 8'h21, 8'h43, 1'b1, 1'b0, took, popped);
    check("bp_take0", 32'(took), 32'd1);
    main_cycle(1'b1, 8'h65, 8'h87, 1'b0, 1'b0, took, popped);
    check("bp_take1", 32'(took), 32'd1);
    for (int i = 0; i < 4; i++) begin
      main_cycle(1'b1, 8'hA9, 8'hCB, 1'b1, 1'b0, took, popped);
      check("bp_rdy", 32'(took), 32'd0);
      check("bp_hold", 32'({out_valid, ov, co, s}), (32'd1 << 10) | mq[0]);
    end
    pops = 0; sent = 1'b0; guard = 0;
    while ((!sent || mq.size() != 0) && guard < 20) begin
      main_cycle(!sent, 8'hA9, 8'hCB, 1'b1, 1'b1, took, popped);
      if (took) sent = 1'b1;
      if (popped) pops++;
      guard++;
    end
    check("bp_pops", 32'(pops), 32'd3);
    check("bp_left", 32'(mq.size()), 32'd0);

    // Asynchronous reset with two beats in flight.
    main_cycle(1'b1, 8'h11, 8'h22, 1'b0, 1'b0, took, popped);
    main_cycle(1'b1, 8'h33, 8'h44, 1'b1, 1'b0, took, popped);
    in_valid = 1'b0;
    @(posedge clk);
    #2;
    check("rst_pre_valid", 32'(out_valid), 32'd1);
    rst = 1'b1;
    #1;
    check("rst_mid_out", 32'({out_valid, ov, co, s}), 32'd0);
    check("rst_mid_rdy", 32'(in_ready), 32'd0);
    mq.delete();
    @(negedge clk);
    rst = 1'b0;
    lat_beat("post_rst", 8'h5A, 8'h3C, 1'b1);

    main_done = 1'b1;
    guard = 0;
    while (!(g_corner[0].done && g_corner[1].done) && guard < 20000) begin
      @(negedge clk);
      guard++;
    end
    check("corners_done", 32'(g_corner[0].done && g_corner[1].done), 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
